alu_ctrl: RTL and testbench
===========================

# alu_ctrl

Multi-cycle ALU controller between instruction decode and the 32-bit `ALU`. It decodes `aluOp`/`funct` into the 4-bit `aluCtr` code the `ALU` consumes and issues single-cycle operations to the external `ALU`. It executes MUL and DIV itself, iteratively over 32 cycles, so the combinational `*` and `/` paths are never timed. Results return through a `start`/`ready`/`done` handshake to the multi-cycle datapath.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width; the iteration count equals `WIDTH`.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: issue request; sampled only while `ready`=1.
- `aluOp` input 2: 00 = ADD (load/store address), 01 = MINUS (branch compare), 10 = decode `funct`, 11 = illegal.
- `funct` input 6: R-type funct field.
- `A`, `B` input `WIDTH`: operands, captured on the accepting edge.
- `aluResult` input `WIDTH`: combinational result returned by the external `ALU`.
- `aluCtr` output 4: registered code to the `ALU`. AND 0000, OR 0001, ADD 0010, MINUS 0110, MUL 0011, DIV 0100.
- `aluA`, `aluB` output `WIDTH`: registered operands to the `ALU`.
- `ready` output 1: high only in IDLE.
- `done` output 1: one-cycle pulse; `out` is valid in this cycle.
- `out` output `WIDTH`: result register; holds its value until the next `done`.
- `illegal` output 1: qualified by `done`; the decode was unsupported.
- `divZero` output 1: qualified by `done`; DIV with `B`=0.

## Operation
- Decode for `aluOp`=10:
  - 100000 → ADD
  - 100010 → MINUS
  - 100100 → AND
  - 100101 → OR
  - 011000 → MUL
  - 011010 → DIV
  - any other funct → illegal
- State machine: IDLE, EXEC, MULT, DIVI, DONE.
- IDLE:
  - On `start`=1, latch `A`/`B` into `aluA`/`aluB` and the decoded code into `aluCtr`.
  - AND/OR/ADD/MINUS/illegal → EXEC.
  - MUL → MULT.
  - DIV with `B`≠0 → DIVI.
  - DIV with `B`=0 → EXEC, with `divZero` pending.
- EXEC: one cycle, then DONE.
  - Normal op: `out` ← `aluResult`.
  - Illegal: `out` ← 0, `illegal` ← 1. `aluCtr` is 0000 on illegal.
  - Divide by zero: `out` ← all ones, `divZero` ← 1.
- MULT: unsigned shift-add, one multiplier bit per cycle, LSB first, 32 iterations.
  - `out` = low `WIDTH` bits of the product; upper bits are discarded.
  - Then DONE.
- DIVI: unsigned restoring division, one quotient bit per cycle, MSB first, 32 iterations.
  - `out` = quotient; the remainder is discarded.
  - Then DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
  - `illegal` and `divZero` are valid only while `done`=1.
  - Both are cleared on the next accepted `start`.
- `start` outside IDLE is ignored; it is neither queued nor an error.
- `aluCtr`, `aluA` and `aluB` hold stable from acceptance through DONE.
- `aluCtr` stays at MUL/DIV during iteration; the `ALU` output is ignored in those states.
- Iteration counter: 6 bits, counts 0..31, and the exit is taken at count 31.

## Timing
- Reset values (the next edge with `reset`=1 forces these):
  - state = IDLE, `ready`=1
  - `done`=0, `out`=0, `aluCtr`=0000, `aluA`=`aluB`=0
  - `illegal`=0, `divZero`=0, counter = 0
- Reset mid-operation aborts with no `done` pulse; `out` returns to 0.
- Reset has priority over `start` on the same edge.
- Latency, with `start` accepted on edge T:
  - Single-cycle op or illegal: `aluCtr` valid in cycle T+1; `done` and `out` valid in cycle T+2.
  - MUL/DIV (`B`≠0): iteration cycles T+1..T+32; `done` in cycle T+33.
  - DIV with `B`=0: `done` in cycle T+2.
- Throughput: `ready` rises in the cycle after `done`. The earliest back-to-back `start` is accepted on the edge ending cycle T+3 (single-cycle op).
- External `ALU` path: `aluCtr`/`aluA`/`aluB` registers → `ALU` → `aluResult` must close within one clock period.

## Test plan
- Reset then idle: `ready`=1, `out`=0, `aluCtr`=0000. Assert `reset` during a MUL at iteration 10 → no `done`, `out`=0, `ready`=1 next cycle.
- `aluOp`=10, `funct`=100010, `A`=7, `B`=9 → `aluCtr`=0110 in T+1; `done` in T+2 with `out`=32'hFFFFFFFE. `aluOp`=00, `A`=100, `B`=4 → `out`=104.
- `funct`=011000, `A`=32'h0001_0001, `B`=32'h0001_0001 → `done` in T+33, `out`=32'h0002_0001 (truncated). `A`=32'hFFFFFFFF, `B`=2 → `out`=32'hFFFFFFFE.
- `funct`=011010, `A`=100, `B`=7 → `done` in T+33, `out`=14. `A`=5, `B`=0 → `done` in T+2, `out`=32'hFFFFFFFF, `divZero`=1.
- `funct`=111111 and `aluOp`=11 → `done` in T+2, `out`=0, `illegal`=1. The following legal op clears `illegal`.
- Hold `start`=1 continuously through a DIV → exactly one `done` per accepted issue, next acceptance in cycle T+34. Operand changes during iteration do not affect `out`.

Source files
------------

// File: rtl/alu_ctrl.sv
// Multi-cycle ALU controller: decodes aluOp/funct for the external ALU and runs
// MUL (shift-add) and DIV (restoring) internally, one bit per cycle.
module alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       aluOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] aluResult,
  output logic [3:0]       aluCtr,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             illegal,
  output logic             divZero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [3:0] CTR_AND   = 4'b0000;
  localparam logic [3:0] CTR_OR    = 4'b0001;
  localparam logic [3:0] CTR_ADD   = 4'b0010;
  localparam logic [3:0] CTR_MINUS = 4'b0110;
  localparam logic [3:0] CTR_MUL   = 4'b0011;
  localparam logic [3:0] CTR_DIV   = 4'b0100;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_MULT = 3'd2;
  localparam logic [2:0] S_DIVI = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       r_state;
  logic [3:0]       r_ctr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out;
  logic             r_illegal;
  logic             r_divzero;
  logic             r_pend_ill;
  logic             r_pend_dz;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_rem;

  logic [3:0]       w_ctr;
  logic             w_ill;
  logic             w_mul;
  logic             w_div;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_diff;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quo;

  always_comb begin
    w_ctr = CTR_AND;
    w_ill = 1'b0;
    w_mul = 1'b0;
    w_div = 1'b0;
    case (aluOp)
      2'b00: w_ctr = CTR_ADD;
      2'b01: w_ctr = CTR_MINUS;
      2'b10: begin
        case (funct)
          6'b100000: w_ctr = CTR_ADD;
          6'b100010: w_ctr = CTR_MINUS;
          6'b100100: w_ctr = CTR_AND;
          6'b100101: w_ctr = CTR_OR;
          6'b011000: begin w_ctr = CTR_MUL; w_mul = 1'b1; end
          6'b011010: begin w_ctr = CTR_DIV; w_div = 1'b1; end
          default:   w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
  end

  // r_shift holds the multiplier (shifting right) for MUL, and the dividend
  // being replaced by quotient bits from the LSB end for DIV.
  assign w_mul_acc  = r_shift[0] ? (r_acc + r_mcand) : r_acc;
  assign w_rem_sh   = {r_rem, r_shift[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_b};
  assign w_q_bit    = ~w_rem_diff[WIDTH];
  assign w_quo      = {r_shift[WIDTH-2:0], w_q_bit};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ctr      <= CTR_AND;
      r_a        <= '0;
      r_b        <= '0;
      r_out      <= '0;
      r_illegal  <= 1'b0;
      r_divzero  <= 1'b0;
      r_pend_ill <= 1'b0;
      r_pend_dz  <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_shift    <= '0;
      r_rem      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a        <= A;
            r_b        <= B;
            r_ctr      <= w_ctr;
            r_illegal  <= 1'b0;
            r_divzero  <= 1'b0;
            r_pend_ill <= w_ill;
            r_pend_dz  <= w_div && (B == '0);
            r_cnt      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_mcand    <= A;
            r_shift    <= w_mul ? B : A;
            if (w_mul)
              r_state <= S_MULT;
            else if (w_div && (B != '0))
              r_state <= S_DIVI;
            else
              r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_pend_ill) begin
            r_out     <= '0;
            r_illegal <= 1'b1;
          end else if (r_pend_dz) begin
            r_out     <= '1;
            r_divzero <= 1'b1;
          end else begin
            r_out <= aluResult;
          end
          r_state <= S_DONE;
        end
        S_MULT: begin
          r_acc   <= w_mul_acc;
          r_mcand <= r_mcand << 1;
          r_shift <= r_shift >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_out   <= w_mul_acc;
            r_state <= S_DONE;
          end
        end
        S_DIVI: begin
          r_rem   <= w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_shift <= w_quo;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_out   <= w_quo;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign aluCtr  = r_ctr;
  assign aluA    = r_a;
  assign aluB    = r_b;
  assign out     = r_out;
  assign illegal = r_illegal;
  assign divZero = r_divzero;
  assign ready   = (r_state == S_IDLE);
  assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: expected results queued at issue, checked on done.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  aluOp = 2'b00;
  logic [5:0]  funct = 6'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] aluResult;
  logic [3:0]  aluCtr;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic        ready;
  logic        done;
  logic [31:0] out;
  logic        illegal;
  logic        divZero;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] out;
    logic        ill;
    logic        dz;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  alu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .aluOp(aluOp), .funct(funct),
    .A(A), .B(B), .aluResult(aluResult), .aluCtr(aluCtr), .aluA(aluA),
    .aluB(aluB), .ready(ready), .done(done), .out(out), .illegal(illegal),
    .divZero(divZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External single-cycle ALU
  always_comb begin
    case (aluCtr)
      4'b0000: aluResult = aluA & aluB;
      4'b0001: aluResult = aluA | aluB;
      4'b0010: aluResult = aluA + aluB;
      4'b0110: aluResult = aluA - aluB;
      default: aluResult = 32'hDEAD_BEEF;
    endcase
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
      end else begin
        mon_e = sb.pop_front();
        checks += 4;
        if (out !== mon_e.out) begin
          failures++; $display("FAIL out: got %h expected %h", out, mon_e.out);
        end
        if (illegal !== mon_e.ill) begin
          failures++; $display("FAIL illegal: got %b expected %b", illegal, mon_e.ill);
        end
        if (divZero !== mon_e.dz) begin
          failures++; $display("FAIL divZero: got %b expected %b", divZero, mon_e.dz);
        end
        if (cyc != mon_e.cyc) begin
          failures++; $display("FAIL done_cycle: got %0d expected %0d", cyc, mon_e.cyc);
        end
        $display("done: out=%h illegal=%b divZero=%b cycle=%0d", out, illegal, divZero, cyc);
      end
    end
  end

  // Called at a negedge with ready=1; returns at the negedge of cycle T+1.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eo, input logic ei,
                       input logic ed, input int lat);
    exp_t e;
    start = 1'b1; aluOp = op; funct = fn; A = a; B = b;
    e.out = eo; e.ill = ei; e.dz = ed; e.cyc = cyc + lat;
    sb.push_back(e);
    $display("issue: aluOp=%b funct=%b A=%h B=%h expect=%h", op, fn, a, b, eo);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL done_timeout: got %0d outstanding expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
    if (out !== 32'd0) begin failures++; $display("FAIL reset_out: got %h expected 0", out); end
    if (aluCtr !== 4'b0000) begin failures++; $display("FAIL reset_aluCtr: got %b expected 0000", aluCtr); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    if ({illegal, divZero} !== 2'b00) begin
      failures++; $display("FAIL reset_flags: got %b expected 00", {illegal, divZero});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    issue(2'b10, 6'b100010, 32'd7, 32'd9, 32'hFFFF_FFFE, 1'b0, 1'b0, 2);
    checks += 3;
    if (aluCtr !== 4'b0110) begin failures++; $display("FAIL minus_aluCtr: got %b expected 0110", aluCtr); end
    if (aluA !== 32'd7 || aluB !== 32'd9) begin
      failures++; $display("FAIL minus_operands: got %h/%h expected 7/9", aluA, aluB);
    end
    if (ready !== 1'b0) begin failures++; $display("FAIL busy_ready: got %b expected 0", ready); end
    drain();
    issue(2'b00, 6'b000000, 32'd100, 32'd4, 32'd104, 1'b0, 1'b0, 2);
    drain();
    issue(2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 2);
    drain();
    issue(2'b10, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 2);
    drain();
  endtask

  task automatic test_mul();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    issue(2'b10, 6'b011000, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0, 1'b0, 33);
    checks++;
    if (aluCtr !== 4'b0011) begin failures++; $display("FAIL mul_aluCtr: got %b expected 0011", aluCtr); end
    drain();
    issue(2'b10, 6'b011000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
    drain();
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; p = a * b;
      issue(2'b10, 6'b011000, a, b, p, 1'b0, 1'b0, 33);
      drain();
    end
  endtask

  task automatic test_div();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    issue(2'b10, 6'b011010, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
    checks++;
    if (aluCtr !== 4'b0100) begin failures++; $display("FAIL div_aluCtr: got %b expected 0100", aluCtr); end
    drain();
    issue(2'b10, 6'b011010, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 2);
    drain();
    issue(2'b10, 6'b011010, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    drain();
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom_range(1, 70000); q = a / b;
      issue(2'b10, 6'b011010, a, b, q, 1'b0, 1'b0, 33);
      drain();
    end
  endtask

  task automatic test_illegal();
    issue(2'b10, 6'b111111, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, 2);
    drain();
    issue(2'b11, 6'b100000, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, 2);
    checks++;
    if (aluCtr !== 4'b0000) begin failures++; $display("FAIL illegal_aluCtr: got %b expected 0000", aluCtr); end
    drain();
    issue(2'b00, 6'b000000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 2);
    drain();
  endtask

  task automatic test_back_to_back();
    issue(2'b01, 6'b000000, 32'd50, 32'd8, 32'd42, 1'b0, 1'b0, 2);
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_done: got %b expected 0", ready); end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_idle: got %b expected 1", ready); end
    issue(2'b00, 6'b000000, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0, 2);
    drain();
  endtask

  task automatic test_hold_start();
    exp_t e;
    int t;
    start = 1'b1; aluOp = 2'b10; funct = 6'b011010; A = 32'd100; B = 32'd7;
    t = cyc;
    e.out = 32'd14; e.ill = 1'b0; e.dz = 1'b0; e.cyc = t + 33;
    sb.push_back(e);
    $display("issue: held-start DIV 100/7 expect=0000000e");
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k < 33) begin
        A = $urandom; B = $urandom; funct = 6'($urandom); aluOp = 2'($urandom);
      end else begin
        aluOp = 2'b00; A = 32'd1; B = 32'd2;
      end
      if (k == 16) begin
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL hold_ready_busy: got %b expected 0", ready); end
      end
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || cyc != t + 34) begin
      failures++; $display("FAIL hold_reaccept: got ready=%b cycle=%0d expected ready=1 cycle=%0d", ready, cyc, t + 34);
    end
    e.out = 32'd3; e.cyc = cyc + 2;
    sb.push_back(e);
    $display("issue: held-start ADD 1+2 expect=00000003");
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    issue(2'b10, 6'b011000, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 1'b0, 1'b0, 33);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    checks += 4;
    if (done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b expected 0", done); end
    if (out !== 32'd0) begin failures++; $display("FAIL abort_out: got %h expected 0", out); end
    if (ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b expected 1", ready); end
    if (aluCtr !== 4'b0000) begin failures++; $display("FAIL abort_aluCtr: got %b expected 0000", aluCtr); end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL abort_idle: got %b expected 1", ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_illegal();
    test_back_to_back();
    test_hold_start();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_empty: got %0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
